// File: rtl/alu_share_arbiter.sv
// Two-port arbiter that time-shares one combinational ALU. It holds the operands for a
// per-opcode latency, then holds the captured result until the requester takes it.
module alu_share_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 4,
  parameter int unsigned RR_EN      = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [4:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [4:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [4:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_branch,
  input  logic              alu_error,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_branch,
  output logic              rsp_error,
  output logic              busy
);

  localparam int unsigned MaxLat = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              rr_last_q;
  logic              grant_id_q;
  logic              any_valid;
  logic              grant;
  logic              accept;
  logic              capture;
  logic              rsp_done;
  logic [4:0]        sel_op;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [CntW-1:0]   lat_m1;

  assign any_valid = req0_valid | req1_valid;
  assign accept    = (state_q == StIdle) && any_valid;

  // On a tie, round-robin picks the port that was not granted last.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) begin
      grant = (RR_EN != 0) ? ~rr_last_q : 1'b0;
    end
  end

  // Gated by resetn so the ready strobes read 0 while reset is held.
  assign req0_ready = resetn & accept & ~grant;
  assign req1_ready = resetn & accept & grant;

  assign sel_op = grant ? req1_op : req0_op;
  assign sel_a  = grant ? req1_a  : req0_a;
  assign sel_b  = grant ? req1_b  : req0_b;

  always_comb begin
    lat_m1 = '0;
    case (sel_op)
      5'd4, 5'd5:       lat_m1 = CntW'(MUL_CYCLES - 1);
      5'd6, 5'd7, 5'd8: lat_m1 = CntW'(DIV_CYCLES - 1);
      default:          lat_m1 = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    rsp_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (any_valid) begin
          state_d = StExec;
          cnt_d   = lat_m1;
        end
      end
      StExec: begin
        if (cnt_q == '0) begin
          state_d = StResp;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d  = StIdle;
          rsp_done = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rr_last_q  <= 1'b1;
      grant_id_q <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_branch <= 1'b0;
      rsp_error  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        alu_op     <= sel_op;
        alu_a      <= sel_a;
        alu_b      <= sel_b;
        grant_id_q <= grant;
        rr_last_q  <= grant;
      end
      if (capture) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= grant_id_q;
        rsp_data   <= alu_c;
        rsp_branch <= alu_branch;
        rsp_error  <= alu_error;
      end else if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a behavioural ALU, a response scoreboard and a
// monitor that pops on every response handshake.
module tb_alu_share_arbiter;

  localparam int W = 32;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  logic         req0_valid = 0, req1_valid = 0;
  logic [4:0]   req0_op = 0, req1_op = 0;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic         rsp_ready = 1;
  logic         req0_ready, req1_ready;
  logic [4:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_c;
  logic         alu_branch, alu_error;
  logic         rsp_valid, rsp_id, rsp_branch, rsp_error, busy;
  logic [W-1:0] rsp_data;

  // Second instance with fixed priority, sharing the request inputs.
  logic         f_req0_ready, f_req1_ready;
  logic [4:0]   f_alu_op;
  logic [W-1:0] f_alu_a, f_alu_b, f_alu_c, f_rsp_data;
  logic         f_alu_branch, f_alu_error;
  logic         f_rsp_valid, f_rsp_id, f_rsp_branch, f_rsp_error, f_busy;

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
    logic         br;
    logic         err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [W+1:0] alu_model(input logic [4:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W-1:0] c;
    logic         br;
    logic         err;
    c = '0; br = 1'b0; err = 1'b0;
    case (op)
      5'd0:       c = a + b;
      5'd1:       c = a - b;
      5'd4, 5'd5: c = a * b;
      5'd6, 5'd8: if (b == 0) err = 1'b1; else c = a / b;
      5'd7:       if (b == 0) err = 1'b1; else c = a % b;
      5'd11:      c = a & b;
      5'd23:      br = (a == b);
      default:    c = '0;
    endcase
    return {err, br, c};
  endfunction

  assign {alu_error, alu_branch, alu_c}       = alu_model(alu_op, alu_a, alu_b);
  assign {f_alu_error, f_alu_branch, f_alu_c} = alu_model(f_alu_op, f_alu_a, f_alu_b);

  alu_share_arbiter #(.DATA_W(W), .MUL_CYCLES(2), .DIV_CYCLES(4), .RR_EN(1)) dut (
    .clock(clock), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_branch(alu_branch), .alu_error(alu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_branch(rsp_branch), .rsp_error(rsp_error), .busy(busy)
  );

  alu_share_arbiter #(.DATA_W(W), .MUL_CYCLES(2), .DIV_CYCLES(4), .RR_EN(0)) dut_fixed (
    .clock(clock), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(f_alu_op), .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_c(f_alu_c),
    .alu_branch(f_alu_branch), .alu_error(f_alu_error),
    .rsp_valid(f_rsp_valid), .rsp_ready(1'b1), .rsp_id(f_rsp_id), .rsp_data(f_rsp_data),
    .rsp_branch(f_rsp_branch), .rsp_error(f_rsp_error), .busy(f_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d (got no event, expected one)", name, cyc);
  endtask

  // Monitor: every response handshake consumes one scoreboard entry.
  always @(negedge clock) begin
    if (resetn && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        timeout("unexpected_rsp");
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", 64'(rsp_id), 64'(mon_e.id));
        check("rsp_data", 64'(rsp_data), 64'(mon_e.data));
        check("rsp_branch", 64'(rsp_branch), 64'(mon_e.br));
        check("rsp_error", 64'(rsp_error), 64'(mon_e.err));
      end
    end
  end

  task automatic drive(input int port, input logic [4:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    if (port == 0) begin
      req0_valid = 1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic wait_grant(input int port);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if ((port == 0) ? req0_ready : req1_ready) return;
    end
    timeout("grant_timeout");
  endtask

  task automatic wait_rsp(input bit chk, input logic [4:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, output int n);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clock);
      if (rsp_valid) begin
        n = i;
        return;
      end
      if (chk) begin
        check("exec_alu_op", 64'(alu_op), 64'(op));
        check("exec_alu_a", 64'(alu_a), 64'(a));
        check("exec_alu_b", 64'(alu_b), 64'(b));
      end
    end
    timeout("rsp_timeout");
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clock);
    end
    timeout("drain_timeout");
  endtask

  task automatic single(input int port, input logic [4:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input rsp_t e);
    @(posedge clock); #1;
    drive(port, op, a, b);
    exp_q.push_back(e);
    wait_grant(port);
    @(posedge clock); #1;
    req0_valid = 0; req1_valid = 0;
  endtask

  int  n;
  int  grants;
  int  f_g0, f_g1;
  int  seen;
  logic exp_id;
  logic g;

  initial begin
    // Reset state, with a request pending to confirm ready is held low.
    req0_valid = 1;
    #1;
    check("reset_req0_ready", 64'(req0_ready), 0);
    check("reset_busy", 64'(busy), 0);
    check("reset_rsp_valid", 64'(rsp_valid), 0);
    check("reset_alu_op", 64'(alu_op), 0);
    req0_valid = 0;
    repeat (2) @(posedge clock);
    #1 resetn = 1;

    // 1-cycle add: response two cycles after accept.
    single(0, 5'd0, 32'd5, 32'd7, '{id: 1'b0, data: 32'd12, br: 1'b0, err: 1'b0});
    wait_rsp(1'b0, 5'd0, 0, 0, n);
    check("add_latency", 64'(n), 2);
    drain();

    // Divide by zero on port 1, operands stable throughout EXEC.
    single(1, 5'd6, 32'd100, 32'd0, '{id: 1'b1, data: 32'd0, br: 1'b0, err: 1'b1});
    wait_rsp(1'b1, 5'd6, 32'd100, 32'd0, n);
    check("div_latency", 64'(n), 5);
    drain();

    // Both ports held valid: round-robin alternates, fixed priority never grants port 1.
    @(posedge clock); #1;
    drive(0, 5'd11, 32'hF0, 32'h3C);
    drive(1, 5'd11, 32'hF0, 32'h3C);
    grants = 0; f_g0 = 0; f_g1 = 0; exp_id = 1'b0;
    for (int i = 0; i < 200 && grants < 8; i++) begin
      @(negedge clock);
      f_g0 += int'(f_req0_ready);
      f_g1 += int'(f_req1_ready);
      if (req0_ready || req1_ready) begin
        g = req1_ready;
        check("rr_grant", 64'(g), 64'(exp_id));
        exp_q.push_back('{id: exp_id, data: 32'h30, br: 1'b0, err: 1'b0});
        exp_id = ~exp_id;
        grants++;
        if (grants == 8) begin
          @(posedge clock); #1;
          req0_valid = 0; req1_valid = 0;
        end
      end
    end
    if (grants < 8) timeout("rr_grants");
    check("fixed_port1_grants", 64'(f_g1), 0);
    check("fixed_port0_granted", 64'(f_g0 >= 3), 1);
    drain();

    // Response stall on a multiply; a new request waits behind it.
    rsp_ready = 0;
    single(0, 5'd4, 32'd3, 32'd9, '{id: 1'b0, data: 32'd27, br: 1'b0, err: 1'b0});
    drive(0, 5'd0, 32'd1, 32'd2);
    wait_rsp(1'b0, 5'd4, 0, 0, n);
    check("mul_latency", 64'(n), 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("stall_rsp_valid", 64'(rsp_valid), 1);
      check("stall_rsp_data", 64'(rsp_data), 27);
      check("stall_req0_ready", 64'(req0_ready), 0);
    end
    exp_q.push_back('{id: 1'b0, data: 32'd3, br: 1'b0, err: 1'b0});
    @(posedge clock); #1;
    rsp_ready = 1;
    @(negedge clock);
    check("handshake_req0_ready", 64'(req0_ready), 0);
    @(negedge clock);
    check("post_stall_accept", 64'(req0_ready), 1);
    @(posedge clock); #1;
    req0_valid = 0;
    drain();

    // Asynchronous reset in the middle of a divide.
    @(posedge clock); #1;
    drive(0, 5'd6, 32'd100, 32'd5);
    wait_grant(0);
    @(posedge clock); #1;
    req0_valid = 0;
    @(posedge clock); #1;
    resetn = 0;
    #1;
    check("rst_busy", 64'(busy), 0);
    check("rst_rsp_valid", 64'(rsp_valid), 0);
    check("rst_alu_op", 64'(alu_op), 0);
    check("rst_alu_a", 64'(alu_a), 0);
    check("rst_alu_b", 64'(alu_b), 0);
    check("rst_rsp_data", 64'(rsp_data), 0);
    @(posedge clock); #1;
    resetn = 1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      seen += int'(rsp_valid);
    end
    check("no_stale_rsp", 64'(seen), 0);
    @(posedge clock); #1;
    drive(0, 5'd11, 32'hF0, 32'h3C);
    drive(1, 5'd0, 32'd1, 32'd1);
    g = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (req0_ready || req1_ready) begin
        g = req1_ready;
        break;
      end
    end
    check("first_grant_after_rst", 64'(g), 0);
    exp_q.push_back('{id: 1'b0, data: 32'h30, br: 1'b0, err: 1'b0});
    @(posedge clock); #1;
    req0_valid = 0; req1_valid = 0;
    drain();

    // Branch-equal flag.
    single(0, 5'd23, 32'h1234, 32'h1234, '{id: 1'b0, data: 32'd0, br: 1'b1, err: 1'b0});
    drain();
    single(1, 5'd23, 32'h1234, 32'h1235, '{id: 1'b1, data: 32'd0, br: 1'b0, err: 1'b0});
    drain();

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
